gg_parse_bit_window: RTL and testbench
======================================

GG_PARSE_BIT_WINDOW -- requirements
Module: gg_parse_bit_window

Interface
REQ-001 Parameter WID, default 128, meaning window width in bits presented to the macroblock lattice.
REQ-002 Parameter PAD, default 32, meaning lookahead bits presented beyond the window.
REQ-003 Parameter CAP, default 256, meaning buffer capacity in bits; SHALL be a multiple of 32 and at least WID+PAD+32.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 flush  in  1  synchronous clear of buffer contents and counters.
REQ-007 in_data  in  32  next stream word, MSB is the earliest bit.
REQ-008 in_valid  in  1  in_data valid.
REQ-009 in_ready  out  1  buffer accepts a word this cycle.
REQ-010 out_bits  out  WID  window, bit WID-1 is the oldest unconsumed bit.
REQ-011 out_pad  out  PAD  the PAD bits following out_bits, bit PAD-1 first.
REQ-012 out_valid  out  1  window and pad fully populated.
REQ-013 mb_start  out  WID  one-hot start marker, bit WID-1 set when out_valid, else zero.
REQ-014 cons_valid  in  1  lattice result valid; consume request.
REQ-015 cons_end  in  WID  one-hot macroblock-end marker from the lattice.
REQ-016 bit_pos  out  32  total bits consumed since reset/flush, wraps modulo 2^32.
REQ-017 err  out  1  sticky protocol error.

Function
REQ-018 Word push SHALL occur when in_valid and in_ready are both high; the word is appended after the newest buffered bit.
REQ-019 in_ready SHALL be high when fill <= CAP-32 and state is not ERR, computed from registered fill only (no combinational path from cons_*).
REQ-020 fill SHALL be a $clog2(CAP)+1-bit count of buffered bits, range 0..CAP.
REQ-021 out_valid SHALL be high exactly when fill >= WID+PAD and state is RUN.
REQ-022 out_bits/out_pad SHALL be driven from registers; bits beyond fill read as zero.
REQ-023 A consume SHALL be accepted only when cons_valid and out_valid are both high.
REQ-024 Consumed length SHALL be WID - k, where k is the index of the single set bit of cons_end (k=WID-1 gives 1 bit, k=0 gives WID bits).
REQ-025 The window SHALL reflect an accepted consume on the next cycle (one-cycle latency); out_valid then re-evaluates against the new fill.
REQ-026 Simultaneous push and consume in one cycle SHALL both take effect: next fill = fill + 32 - len.
REQ-027 cons_valid with cons_end zero or multi-hot, or with out_valid low, SHALL set err and enter ERR; no bits are consumed.
REQ-028 bit_pos SHALL increment by len on each accepted consume, wrapping modulo 2^32.
REQ-029 State machine: FILL (fill < WID+PAD) -> RUN when fill >= WID+PAD; RUN -> FILL when fill drops below WID+PAD; any state -> ERR on REQ-027; ERR exits only by reset or flush to FILL.
REQ-030 In ERR: in_ready low, out_valid low, mb_start zero, buffer contents frozen.
REQ-031 flush SHALL take priority over push and consume in the same cycle: fill=0, bit_pos=0, err=0, state FILL.

Reset
REQ-032 On reset assertion, immediately: fill=0, buffer=0, bit_pos=0, err=0, state FILL, out_valid=0, in_ready=0, mb_start=0, out_bits=0, out_pad=0.
REQ-033 in_ready SHALL rise on the first clock edge after reset deasserts.
REQ-034 Reset mid-stream SHALL discard all buffered bits; no partial word is retained.

Structure
REQ-035 The state enum (FILL, RUN, ERR) and constants WID/PAD/CAP defaults SHALL reside in the shared gg parse package.
REQ-036 The one-hot-to-length encoder, including the zero/multi-hot check, SHALL be a sub-module gg_onehot_len.
REQ-037 Buffer shifting SHALL use a single barrel shift by len (0..WID) per cycle; no multi-cycle shifting.

Verification
REQ-038 Push 5 words 0xB0A4_C5D1, ... -> out_valid rises on the cycle after the 5th push (fill=160), out_bits[127:96]=0xB0A4C5D1, mb_start[127]=1.
REQ-039 With fill=160, consume cons_end[90]=1 (len 38) -> next cycle fill=122, out_valid=0, state FILL, bit_pos=38, out_bits[127] equals original stream bit 38.
REQ-040 Push and consume cons_end[0]=1 (len 128) in the same cycle at fill=224 -> next fill=128, bit_pos advances by 128.
REQ-041 Fill to 256 -> in_ready low; consume len 64 -> in_ready high the following cycle.
REQ-042 cons_valid with cons_end=0 -> err=1, in_ready=0, out_valid=0; flush -> err=0, fill=0, state FILL next cycle.
REQ-043 Assert reset while out_valid=1 and in_valid=1 -> all outputs zero immediately; after release, first accepted word appears at out_bits[127:96].

Source files
------------

// File: rtl/gg_parse_pkg.sv
// Shared definitions for the gg parse bit-window block: default geometry and FSM states.
package gg_parse_pkg;

  localparam int GG_WID_DEFAULT = 128;
  localparam int GG_PAD_DEFAULT = 32;
  localparam int GG_CAP_DEFAULT = 256;
  localparam int GG_WORD_BITS   = 32;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } gg_state_e;

endpackage

// File: rtl/gg_onehot_len.sv
// Converts the lattice's one-hot macroblock-end marker into a consumed length
// (bit k set -> WID-k bits) and flags markers that are not exactly one-hot.
module gg_onehot_len
  import gg_parse_pkg::*;
#(
  parameter int WID = GG_WID_DEFAULT,
  parameter int LW  = $clog2(WID + 1)
) (
  input  logic [WID-1:0] cons_end,
  output logic [LW-1:0]  len,
  output logic           onehot
);

  logic seen;
  logic multi;

  // Scan every marker bit; remember whether one or several were set.
  always_comb begin
    len   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WID; i++) begin
      if (cons_end[i]) begin
        if (seen) begin
          multi = 1'b1;
        end
        seen = 1'b1;
        len  = LW'(WID - i);
      end
    end
    onehot = seen && !multi;
  end

endmodule

// File: rtl/gg_parse_bit_window.sv
// Bit-stream window buffer: packs 32-bit words MSB-first into a CAP-bit shift
// buffer, presents the oldest WID+PAD bits, and drops a variable-length prefix
// each time the lattice reports a macroblock end.
module gg_parse_bit_window
  import gg_parse_pkg::*;
#(
  parameter int WID = GG_WID_DEFAULT,
  parameter int PAD = GG_PAD_DEFAULT,
  parameter int CAP = GG_CAP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WID-1:0]   out_bits,
  output logic [PAD-1:0]   out_pad,
  output logic             out_valid,
  output logic [WID-1:0]   mb_start,
  input  logic             cons_valid,
  input  logic [WID-1:0]   cons_end,
  output logic [31:0]      bit_pos,
  output logic             err
);

  localparam int FW = $clog2(CAP) + 1;
  localparam int LW = $clog2(WID + 1);

  localparam logic [FW-1:0] THRESH    = FW'(WID + PAD);
  localparam logic [FW-1:0] READY_MAX = FW'(CAP - GG_WORD_BITS);
  localparam logic [FW-1:0] WORD_LEN  = FW'(GG_WORD_BITS);

  // Buffer is MSB-aligned: bit CAP-1 is the oldest unconsumed bit and every
  // bit at or beyond the fill level is kept at zero.
  logic [CAP-1:0]  win_q, win_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [31:0]     bit_pos_q, bit_pos_d;
  gg_state_e       state_q, state_d;
  logic            started_q;

  logic [LW-1:0]   cons_len;
  logic            cons_onehot;
  logic            push;
  logic            accept;
  logic            proto_err;
  logic [FW-1:0]   len_eff;
  logic [CAP-1:0]  shifted;
  logic [CAP-1:0]  word_ext;
  logic [CAP-1:0]  placed;

  gg_onehot_len #(
    .WID (WID),
    .LW  (LW)
  ) u_onehot_len (
    .cons_end (cons_end),
    .len      (cons_len),
    .onehot   (cons_onehot)
  );

  assign out_valid = (state_q == ST_RUN) && (fill_q >= THRESH);
  assign in_ready  = started_q && (state_q != ST_ERR) && (fill_q <= READY_MAX);
  assign out_bits  = win_q[CAP-1 -: WID];
  assign out_pad   = win_q[CAP-WID-1 -: PAD];
  assign mb_start  = {out_valid, {(WID-1){1'b0}}};
  assign bit_pos   = bit_pos_q;
  assign err       = (state_q == ST_ERR);

  assign push      = in_valid && in_ready;
  assign accept    = cons_valid && out_valid && cons_onehot;
  assign proto_err = cons_valid && !accept;

  // Datapath: drop the consumed prefix with one barrel shift, then drop the
  // new word in directly behind the surviving bits; flush wipes everything.
  always_comb begin
    len_eff   = accept ? FW'(cons_len) : '0;
    shifted   = win_q << len_eff;
    word_ext  = {in_data, {(CAP-GG_WORD_BITS){1'b0}}};
    placed    = word_ext >> (fill_q - len_eff);
    win_d     = push ? (shifted | placed) : shifted;
    fill_d    = fill_q - len_eff + (push ? WORD_LEN : '0);
    bit_pos_d = bit_pos_q + 32'(len_eff);
    if (flush) begin
      win_d     = '0;
      fill_d    = '0;
      bit_pos_d = '0;
    end
  end

  // Control: error is sticky until flush; otherwise RUN tracks the next fill.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_FILL;
    end else if (proto_err || (state_q == ST_ERR)) begin
      state_d = ST_ERR;
    end else if (fill_d >= THRESH) begin
      state_d = ST_RUN;
    end else begin
      state_d = ST_FILL;
    end
  end

  // State registers; started_q holds in_ready low until the first edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q     <= '0;
      fill_q    <= '0;
      bit_pos_q <= '0;
      state_q   <= ST_FILL;
      started_q <= 1'b0;
    end else begin
      win_q     <= win_d;
      fill_q    <= fill_d;
      bit_pos_q <= bit_pos_d;
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gg_parse_bit_window.sv
// Directed bench for gg_parse_bit_window with a bit-queue reference model.
module tb_gg_parse_bit_window;

  localparam int WID = 128;
  localparam int PAD = 32;
  localparam int CAP = 256;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WID-1:0]   out_bits;
  logic [PAD-1:0]   out_pad;
  logic             out_valid;
  logic [WID-1:0]   mb_start;
  logic             cons_valid = 1'b0;
  logic [WID-1:0]   cons_end = '0;
  logic [31:0]      bit_pos;
  logic             err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] words [0:7];

  gg_parse_bit_window #(
    .WID (WID),
    .PAD (PAD),
    .CAP (CAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_bits   (out_bits),
    .out_pad    (out_pad),
    .out_valid  (out_valid),
    .mb_start   (mb_start),
    .cons_valid (cons_valid),
    .cons_end   (cons_end),
    .bit_pos    (bit_pos),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Reference model: the buffered stream as a plain queue of bits.
  bit          mq[$];
  logic [31:0] m_pos = '0;
  logic        m_err = 1'b0;
  logic        m_started = 1'b0;
  logic        m_push;
  logic        m_ov;
  int          m_len;

  function automatic logic m_valid();
    return !m_err && (mq.size() >= WID + PAD);
  endfunction

  function automatic logic m_ready();
    return m_started && !m_err && (mq.size() <= CAP - 32);
  endfunction

  function automatic logic [WID-1:0] m_bits();
    logic [WID-1:0] v;
    v = '0;
    for (int i = 0; i < WID; i++) begin
      if (i < mq.size()) v[WID-1-i] = mq[i];
    end
    return v;
  endfunction

  function automatic logic [PAD-1:0] m_pad();
    logic [PAD-1:0] v;
    v = '0;
    for (int i = 0; i < PAD; i++) begin
      if (WID + i < mq.size()) v[PAD-1-i] = mq[WID+i];
    end
    return v;
  endfunction

  function automatic logic [WID-1:0] oh(input int k);
    logic [WID-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Model update on every active edge, from the inputs driven before it.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_pos = '0;
      m_err = 1'b0;
      m_started = 1'b0;
    end else begin
      m_push = in_valid && m_ready();
      m_ov = m_valid();
      if (flush) begin
        mq.delete();
        m_pos = '0;
        m_err = 1'b0;
      end else begin
        if (cons_valid) begin
          if (m_ov && ($countones(cons_end) == 1)) begin
            m_len = 0;
            for (int i = 0; i < WID; i++) begin
              if (cons_end[i]) m_len = WID - i;
            end
            for (int j = 0; j < m_len; j++) void'(mq.pop_front());
            m_pos = m_pos + 32'(m_len);
          end else begin
            m_err = 1'b1;
          end
        end
        if (m_push) begin
          for (int b = 31; b >= 0; b--) mq.push_back(in_data[b]);
        end
      end
      m_started = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [WID-1:0] act, input logic [WID-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("out_valid", WID'(out_valid), WID'(m_valid()));
    checkOutput("in_ready", WID'(in_ready), WID'(m_ready()));
    checkOutput("err", WID'(err), WID'(m_err));
    checkOutput("bit_pos", WID'(bit_pos), WID'(m_pos));
    checkOutput("out_bits", out_bits, m_bits());
    checkOutput("out_pad", WID'(out_pad), WID'(m_pad()));
    checkOutput("mb_start", mb_start, m_valid() ? oh(WID-1) : '0);
  end

  task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic cv,
                               input logic [WID-1:0] ce, input logic fl);
    in_valid   = iv;
    in_data    = d;
    cons_valid = cv;
    cons_end   = ce;
    flush      = fl;
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    cons_valid = 1'b0;
    cons_end   = '0;
    flush      = 1'b0;
  endtask

  initial begin
    words[0] = 32'hB0A4C5D1; words[1] = 32'h13579BDF;
    words[2] = 32'h2468ACE0; words[3] = 32'hDEADBEEF;
    words[4] = 32'h0F1E2D3C; words[5] = 32'hA5A55A5A;
    words[6] = 32'h01234567; words[7] = 32'h89ABCDEF;

    #2 reset = 1'b1;
    #1;
    checkOutput("rst_valid", WID'(out_valid), '0);
    checkOutput("rst_ready", WID'(in_ready), '0);
    checkOutput("rst_bits", out_bits, '0);
    checkOutput("rst_pos", WID'(bit_pos), '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("ready_held", WID'(in_ready), '0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_rise", WID'(in_ready), WID'(1'b1));

    // Five words fill the window plus lookahead.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, words[i], 1'b0, '0, 1'b0);
      if (i == 3) checkOutput("valid_128", WID'(out_valid), '0);
    end
    checkOutput("valid_160", WID'(out_valid), WID'(1'b1));
    checkOutput("head_160", WID'(out_bits[127:96]), WID'(32'hB0A4C5D1));
    checkOutput("mbs_160", WID'(mb_start[127]), WID'(1'b1));
    checkOutput("pad_160", WID'(out_pad), WID'(32'h0F1E2D3C));

    // Consume 38 bits.
    applyStimulus(1'b0, '0, 1'b1, oh(90), 1'b0);
    checkOutput("c38_valid", WID'(out_valid), '0);
    checkOutput("c38_pos", WID'(bit_pos), WID'(32'd38));
    checkOutput("c38_head", WID'(out_bits[127:122]), WID'(6'h35));

    // Flush wins over push and an otherwise illegal consume.
    applyStimulus(1'b1, words[5], 1'b1, oh(0), 1'b1);
    checkOutput("fl_pos", WID'(bit_pos), '0);
    checkOutput("fl_err", WID'(err), '0);
    checkOutput("fl_bits", out_bits, '0);

    // Simultaneous push and full-window consume at fill 224.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, words[i], 1'b0, '0, 1'b0);
    applyStimulus(1'b1, words[7], 1'b1, oh(0), 1'b0);
    checkOutput("pc_pos", WID'(bit_pos), WID'(32'd128));
    checkOutput("pc_valid", WID'(out_valid), '0);
    checkOutput("pc_head", WID'(out_bits[127:96]), WID'(32'h0F1E2D3C));

    // Full buffer back-pressure.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h11111111 * (i + 1), 1'b0, '0, 1'b0);
    checkOutput("full_ready", WID'(in_ready), '0);
    applyStimulus(1'b1, 32'hFFFF0000, 1'b1, oh(64), 1'b0);
    checkOutput("c64_ready", WID'(in_ready), WID'(1'b1));
    checkOutput("c64_pos", WID'(bit_pos), WID'(32'd192));

    // Mixed traffic with assorted lengths, including single-bit consumes.
    for (int i = 0; i < 16; i++) begin
      logic cv;
      int   k;
      cv = m_valid();
      k  = (i % 5 == 4) ? WID - 1 : (i * 37) % WID;
      applyStimulus((i % 3) != 0, 32'h9E3779B9 * (i + 1), cv, oh(k), 1'b0);
    end

    // Zero marker raises the sticky error; flush clears it.
    applyStimulus(1'b0, '0, 1'b1, '0, 1'b0);
    checkOutput("e0_err", WID'(err), WID'(1'b1));
    checkOutput("e0_ready", WID'(in_ready), '0);
    checkOutput("e0_valid", WID'(out_valid), '0);
    applyStimulus(1'b1, 32'h55555555, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("e0_clr", WID'(err), '0);
    checkOutput("e0_rdy", WID'(in_ready), WID'(1'b1));

    // Multi-hot marker.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, words[i], 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, oh(3) | oh(5), 1'b0);
    checkOutput("mh_err", WID'(err), WID'(1'b1));
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

    // Consume while the window is not yet valid.
    applyStimulus(1'b1, words[2], 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, oh(10), 1'b0);
    checkOutput("nv_err", WID'(err), WID'(1'b1));
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

    // Reset mid-stream with a word on offer.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, words[i], 1'b0, '0, 1'b0);
    checkOutput("pre_valid", WID'(out_valid), WID'(1'b1));
    in_valid = 1'b1;
    in_data  = words[0];
    #2 reset = 1'b1;
    #1;
    checkOutput("mr_valid", WID'(out_valid), '0);
    checkOutput("mr_ready", WID'(in_ready), '0);
    checkOutput("mr_bits", out_bits, '0);
    checkOutput("mr_pad", WID'(out_pad), '0);
    checkOutput("mr_mbs", mb_start, '0);
    @(negedge clk);
    reset = 1'b0;
    in_data = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mr_rise", WID'(in_ready), WID'(1'b1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("mr_first", WID'(out_bits[127:96]), WID'(32'hCAFEF00D));

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
